id_ex_hazard_unit: RTL

ID_EX_HAZARD_UNIT -- requirements
Module: id_ex_hazard_unit

---
 rtl/id_ex_hazard_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_unit.sv
// ID/EX hazard unit: load-use stall and taken-branch flush sequencing.
// Define HAZARD_STATS_EN to add saturating stall_count / flush_count outputs.
module id_ex_hazard_unit #(
    parameter int FLUSH_LEN = 2,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              idex_memread,
    input  logic [4:0]        idex_rt,
    input  logic              branch_taken,
    input  logic [1:0]        ctrl_wb,
    input  logic [3:0]        ctrl_m,
    input  logic [3:0]        ctrl_ex,
    output logic [1:0]        wb_gated,
    output logic [3:0]        m_gated,
    output logic [3:0]        ex_gated,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              exmem_flush,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0] stall_count,
    output logic [STAT_W-1:0] flush_count,
`endif
    output logic [1:0]        state
);

    // state | meaning
    // RUN   | normal issue, checks for branch flush and load-use stall
    // STALL | previous cycle held PC and IF/ID for a load-use bubble
    // FLUSH | bubbling ID_EX for the remaining cycles after a taken branch
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [2:0] RELOAD     = 3'(FLUSH_LEN - 1);
    localparam logic [1:0] AFTER_BRCH = (FLUSH_LEN == 1) ? S_RUN : S_FLUSH;

    logic       load_use;
    logic       do_stall;
    logic [1:0] state_nxt;
    logic [2:0] counter;
    logic [2:0] counter_nxt;

    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        wb_gated    = ctrl_wb;
        m_gated     = ctrl_m;
        ex_gated    = ctrl_ex;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        do_stall    = 1'b0;
        state_nxt   = S_RUN;
        counter_nxt = 3'd0;

        if (!rst) begin
            case (state)
                S_RUN, S_STALL: begin
                    if (branch_taken) begin
                        wb_gated    = '0;
                        m_gated     = '0;
                        ex_gated    = '0;
                        ifid_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_nxt   = AFTER_BRCH;
                        counter_nxt = RELOAD;
                    end else if (load_use) begin
                        wb_gated   = '0;
                        m_gated    = '0;
                        ex_gated   = '0;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        do_stall   = 1'b1;
                        state_nxt  = S_STALL;
                    end
                end
                S_FLUSH: begin
                    wb_gated   = '0;
                    m_gated    = '0;
                    ex_gated   = '0;
                    ifid_flush = 1'b1;
                    if (branch_taken) begin
                        exmem_flush = 1'b1;
                        state_nxt   = AFTER_BRCH;
                        counter_nxt = RELOAD;
                    end else if (counter > 3'd1) begin
                        state_nxt   = S_FLUSH;
                        counter_nxt = counter - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            counter <= 3'd0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] ONE = STAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (do_stall && (stall_count != '1))
                stall_count <= stall_count + ONE;
            if (exmem_flush && (flush_count != '1))
                flush_count <= flush_count + ONE;
        end
    end
`endif

endmodule
